// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the fetch PC, runs a variable-latency request/ack handshake to
// instruction memory, buffers a returned word across stalls and drops
// words made stale by a decode-stage redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        pc_src_d_i,
    input  logic [31:0] pc_branch_d_i,
    input  logic        jump_d_i,
    input  logic [31:0] pc_jump_d_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_f_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_plus_4_d_o,
    output logic        valid_d_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDiscard
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_f;
    logic [31:0] pc_f_next;
    logic [31:0] hold_buf;
    logic [31:0] hold_buf_next;
    logic [31:0] redir_pc;
    logic [31:0] redir_pc_next;
    logic [31:0] instr_d;
    logic [31:0] instr_d_next;
    logic [31:0] pc_plus_4_d;
    logic [31:0] pc_plus_4_d_next;
    logic        valid_d;
    logic        valid_d_next;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus_4;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic        req;

    // Redirects are ignored while decode is held; jump beats branch.
    assign redirect  = (pc_src_d_i | jump_d_i) & ~stall_d_i;
    assign target    = (jump_d_i ? pc_jump_d_i : pc_branch_d_i) & 32'hFFFF_FFFC;
    assign pc_plus_4 = pc_f + 32'd4;

    // Fetch FSM next-state, PC update and handshake outputs.
    always_comb begin
        state_next    = state;
        pc_f_next     = pc_f;
        hold_buf_next = hold_buf;
        redir_pc_next = redir_pc;
        req           = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata_i;
        unique case (state)
            StIdle: begin
                state_next = StReq;
            end
            StReq: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    if (redirect) begin
                        pc_f_next = target;
                    end else if (stall_f_i | stall_d_i) begin
                        // Word cannot enter IF/ID yet; park it so no refetch is needed.
                        hold_buf_next = imem_rdata_i;
                        state_next    = StHold;
                    end else begin
                        deliver   = 1'b1;
                        pc_f_next = pc_plus_4;
                    end
                end else if (redirect) begin
                    // Address must stay stable until ack, so remember the target.
                    redir_pc_next = target;
                    state_next    = StDiscard;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_f_next  = target;
                    state_next = StReq;
                end else if (~stall_f_i & ~stall_d_i) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_buf;
                    pc_f_next     = pc_plus_4;
                    state_next    = StReq;
                end
            end
            StDiscard: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    pc_f_next  = redirect ? target : redir_pc;
                    state_next = StReq;
                end else if (redirect) begin
                    redir_pc_next = target;
                end
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // IF/ID next value: stall holds, flush clears, otherwise deliver or bubble.
    always_comb begin
        instr_d_next     = 32'd0;
        pc_plus_4_d_next = 32'd0;
        valid_d_next     = 1'b0;
        if (stall_d_i) begin
            instr_d_next     = instr_d;
            pc_plus_4_d_next = pc_plus_4_d;
            valid_d_next     = valid_d;
        end else if (flush_d_i) begin
            instr_d_next     = 32'd0;
            pc_plus_4_d_next = 32'd0;
            valid_d_next     = 1'b0;
        end else if (deliver) begin
            instr_d_next     = deliver_instr;
            pc_plus_4_d_next = pc_plus_4;
            valid_d_next     = 1'b1;
        end
    end

    // State, PC, buffers and IF/ID register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= StIdle;
            pc_f        <= RESET_PC;
            hold_buf    <= 32'd0;
            redir_pc    <= 32'd0;
            instr_d     <= 32'd0;
            pc_plus_4_d <= 32'd0;
            valid_d     <= 1'b0;
        end else begin
            state       <= state_next;
            pc_f        <= pc_f_next;
            hold_buf    <= hold_buf_next;
            redir_pc    <= redir_pc_next;
            instr_d     <= instr_d_next;
            pc_plus_4_d <= pc_plus_4_d_next;
            valid_d     <= valid_d_next;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_f;
    assign pc_f_o        = pc_f;
    assign instr_d_o     = instr_d;
    assign pc_plus_4_d_o = pc_plus_4_d;
    assign valid_d_o     = valid_d;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. Owns the fetch PC, drives a variable-latency instruction-memory request/acknowledge port, and presents the fetched instruction to decode. Consumes `stall_f`, `stall_d` and `flush_d` from the hazard unit, plus branch/jump redirects from decode. Upstream of decode and of the hazard unit's decode-side inputs.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `stall_f_i` input 1: freeze the fetch PC; a returning instruction is buffered.
- `stall_d_i` input 1: hold the IF/ID register; masks redirects and `flush_d_i`.
- `flush_d_i` input 1: clear the IF/ID register to a bubble.
- `pc_src_d_i` input 1: branch taken in decode.
- `pc_branch_d_i` input 32: branch target.
- `jump_d_i` input 1: jump taken in decode (j/jal/jr combined).
- `pc_jump_d_i` input 32: jump target.
- `imem_req_o` output 1: fetch request.
- `imem_addr_o` output 32: fetch address, word aligned.
- `imem_ack_i` input 1: data valid; may be asserted in the same cycle as `imem_req_o`.
- `imem_rdata_i` input 32: instruction, valid only when `imem_ack_i` is high.
- `pc_f_o` output 32: current fetch PC.
- `instr_d_o` output 32: IF/ID instruction.
- `pc_plus_4_d_o` output 32: IF/ID PC+4.
- `valid_d_o` output 1: IF/ID holds a real instruction (0 means bubble).

## Operation
- Redirect is `(pc_src_d_i | jump_d_i) & ~stall_d_i`.
- When both redirect sources are high, `jump_d_i` wins.
- Target bits [1:0] are ignored and forced to 00.
- PC+4 wraps modulo 2^32.
- The FSM has four states: IDLE, REQ, HOLD and DISCARD. The reset state is IDLE.
- **IDLE:** `imem_req_o` = 0. Moves to REQ on the next edge unconditionally.
- **REQ:** `imem_req_o` = 1 and `imem_addr_o` = `pc_f`.
  - If `imem_ack_i` and redirect: drop the data, `pc_f` <= target, stay in REQ.
  - If `imem_ack_i` and `stall_f_i`: capture `imem_rdata_i` into the hold buffer, go to HOLD.
  - If `imem_ack_i`, otherwise: deliver the instruction; `pc_f` <= `pc_f`+4, stay in REQ.
  - If no ack and redirect: save the target in `redir_pc`, go to DISCARD. `pc_f` and `imem_addr_o` stay stable, because the address is held until ack.
  - If no ack and no redirect: stay in REQ.
- **HOLD:** `imem_req_o` = 0.
  - If redirect: drop the buffer, `pc_f` <= target, go to REQ.
  - Else if `~stall_f_i`: deliver the buffer, `pc_f` <= `pc_f`+4, go to REQ.
- **DISCARD:** `imem_req_o` = 1 with the old `pc_f`.
  - A further redirect overwrites `redir_pc`.
  - On `imem_ack_i`: drop the data, `pc_f` <= `redir_pc` (or the same-cycle redirect target, if one is present), go to REQ.
- **IF/ID update, in priority order:**
  1. `stall_d_i`: hold all of `instr_d_o`, `pc_plus_4_d_o` and `valid_d_o`.
  2. `flush_d_i`: load `instr_d_o` = 0, `pc_plus_4_d_o` = 0, `valid_d_o` = 0.
  3. Deliver: load the instruction, `pc_f`+4, and `valid_d_o` = 1.
  4. Otherwise: load a bubble (all zeros).
- Delivery also requires `~stall_d_i`. If `stall_f_i` is low while `stall_d_i` is high, the instruction goes to the hold buffer instead.

## Timing
- **Reset:**
  - `pc_f_o` = `RESET_PC`.
  - `instr_d_o` = 0, `pc_plus_4_d_o` = 0, `valid_d_o` = 0.
  - `imem_req_o` = 0; state IDLE; hold buffer 0; `redir_pc` 0.
  - Asserting reset mid-request abandons the request immediately. A late ack after release is ignored, because IDLE does not sample `imem_ack_i`.
- **Request start:** the first `imem_req_o` is in the second cycle after `rst_ni` rises.
- **Throughput:** with zero-wait memory (ack in the same cycle as the request), one instruction per cycle. The instruction appears on `instr_d_o` the edge after ack.
- **Memory wait:** with N wait cycles, IF/ID receives N bubbles per instruction.
- **Redirect penalty:**
  - Redirect asserted in cycle t: `pc_f_o` = target after edge t (REQ-with-ack or HOLD). The IF/ID slot at edge t is a bubble via `flush_d_i`.
  - In the DISCARD case, `pc_f_o` changes on the edge of the outstanding ack.
- **Stall:** with `stall_f_i`/`stall_d_i` high for k cycles, `pc_f_o` and IF/ID are constant for k cycles and the pending instruction is buffered. It is delivered on the first edge after release, with no refetch.

## Test plan
- **Reset:** `RESET_PC` = 0x100, zero-wait memory returning addr^0xFFFF. Response: `pc_f_o` sequence 0x100, 0x104, 0x108; `instr_d_o` = 0x0000FEFF at 0x104+… with `valid_d_o`=1 from the 3rd cycle after reset release; all outputs 0 while `rst_ni`=0.
- **Two-wait memory:** ack two cycles after each request. Response: `valid_d_o` pattern 0,0,1 repeating; `pc_plus_4_d_o` = 0x104, 0x108, ….
- **Stall:** `stall_f_i`=`stall_d_i`=1 for 3 cycles while an ack arrives at 0x108. Response: IF/ID holds the 0x104 instruction; after release it loads the 0x108 instruction with no new `imem_req_o` for 0x108.
- **Redirect during wait:** redirect `pc_src_d_i`=1 to `pc_branch_d_i`=0x2003 while a request to 0x10C is unacked. Response: `imem_addr_o` stays 0x10C until ack, the 0x10C data is dropped, the next request goes to 0x2000, and `valid_d_o` stays 0 for the dropped word.
- **Simultaneous jump and branch:** `jump_d_i`=1 to 0x400 and `pc_src_d_i`=1 to 0x800 in the same cycle. Response: `pc_f_o`=0x400.
- **Stall masks flush:** `stall_d_i`=1 together with `flush_d_i`=1 and `pc_src_d_i`=1. Response: IF/ID unchanged and `pc_f_o` unchanged.
